// File: rtl/zueirai_int_ctrl.sv
// ZueiraI interrupt controller: edge-latched sources, fixed-priority arbitration,
// vector fetch window and a small memory-mapped register block on the core bus.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no request outstanding; arbitrate enabled pending sources
// REQ   | flags_INTERRUPT high, waiting for the core's acknowledge
// SVC   | source sel is being serviced, waiting for RETI
module zueirai_int_ctrl #(
    parameter int          N_SRC        = 4,
    parameter logic [7:0]  INT_VEC_ADDR = 8'hFE,
    parameter logic [1:0]  MMIO_PAGE    = 2'd3,
    parameter logic [7:0]  MMIO_BASE    = 8'hF0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src,
    input  logic [11:0]      ctrl_MEM,
    input  logic [7:0]       wdata_MEM,
    output logic [7:0]       rdata_MEM,
    output logic             hit_MEM,
    output logic             flags_INTERRUPT,
    input  logic [1:0]       ctrl_INTERRUPT,
    output logic [N_SRC-1:0] in_service
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_SVC  = 2'd2;

    localparam logic [7:0] LAST_OFF = 8'(2 + 2 * N_SRC);

    logic [1:0]       state;
    logic [1:0]       sel;
    logic [N_SRC-1:0] ie;
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] pend_n;
    logic [N_SRC-1:0] prev_irq;
    logic [N_SRC-1:0] irq_edge;
    logic [7:0]       vec_pc [N_SRC];
    logic [1:0]       vec_pg [N_SRC];

    logic [7:0]       addr;
    logic [1:0]       page;
    logic             load;
    logic             write;
    logic [7:0]       off;
    logic             reg_hit;
    logic             vec_hit;
    logic             wr_en;

    logic [N_SRC-1:0] sel_mask;
    logic             sel_pend;
    logic             sel_ie;
    logic [7:0]       sel_pc;
    logic [1:0]       sel_pg;
    logic             arb_any;
    logic [1:0]       arb_sel;
    logic             ack_now;

    assign addr  = ctrl_MEM[7:0];
    assign page  = ctrl_MEM[9:8];
    assign load  = ctrl_MEM[10];
    assign write = ctrl_MEM[11];
    assign off   = addr - MMIO_BASE;

    assign reg_hit = (page == MMIO_PAGE) && (addr >= MMIO_BASE) && (off <= LAST_OFF);
    assign vec_hit = (page == 2'd0) &&
                     ((addr == INT_VEC_ADDR) || (addr == INT_VEC_ADDR + 8'd1));
    assign wr_en   = write && reg_hit;

    assign irq_edge = irq_src & ~prev_irq;
    assign ack_now  = (state == ST_REQ) && ctrl_INTERRUPT[0];

    always_comb begin
        sel_mask = '0;
        sel_pc   = '0;
        sel_pg   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (sel == 2'(i)) begin
                sel_mask[i] = 1'b1;
                sel_pc      = vec_pc[i];
                sel_pg      = vec_pg[i];
            end
        end
    end

    assign sel_pend = |(pend & sel_mask);
    assign sel_ie   = |(ie & sel_mask);

    // Scan downward so the lowest set index wins.
    always_comb begin
        arb_any = |(pend & ie);
        arb_sel = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (pend[i] && ie[i]) begin
                arb_sel = 2'(i);
            end
        end
    end

    // A fresh edge is applied last so it survives a same-cycle W1C or ack clear.
    always_comb begin
        pend_n = pend;
        if (wr_en && (off == 8'd1)) begin
            pend_n = pend_n & ~wdata_MEM[N_SRC-1:0];
        end
        if (ack_now) begin
            pend_n = pend_n & ~sel_mask;
        end
        pend_n = pend_n | irq_edge;
    end

    always_comb begin
        rdata_MEM = '0;
        hit_MEM   = 1'b0;
        if (!rst && load && reg_hit) begin
            hit_MEM = 1'b1;
            if (off == 8'd0) begin
                rdata_MEM = 8'(ie);
            end else if (off == 8'd1) begin
                rdata_MEM = 8'(pend);
            end else if (off == 8'd2) begin
                rdata_MEM = {state, 4'b0000, sel};
            end else begin
                for (int i = 0; i < N_SRC; i++) begin
                    if (off == 8'(3 + 2 * i)) begin
                        rdata_MEM = vec_pc[i];
                    end
                    if (off == 8'(4 + 2 * i)) begin
                        rdata_MEM = {6'b000000, vec_pg[i]};
                    end
                end
            end
        end else if (!rst && load && vec_hit) begin
            hit_MEM   = 1'b1;
            rdata_MEM = (addr == INT_VEC_ADDR) ? sel_pc : {6'b000000, sel_pg};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            sel             <= '0;
            ie              <= '0;
            pend            <= '0;
            prev_irq        <= '0;
            flags_INTERRUPT <= 1'b0;
            in_service      <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                vec_pc[i] <= '0;
                vec_pg[i] <= '0;
            end
        end else begin
            prev_irq <= irq_src;
            pend     <= pend_n;
            if (wr_en && (off == 8'd0)) begin
                ie <= wdata_MEM[N_SRC-1:0];
            end
            for (int i = 0; i < N_SRC; i++) begin
                if (wr_en && (off == 8'(3 + 2 * i))) begin
                    vec_pc[i] <= wdata_MEM;
                end
                if (wr_en && (off == 8'(4 + 2 * i))) begin
                    vec_pg[i] <= wdata_MEM[1:0];
                end
            end

            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        sel             <= arb_sel;
                        state           <= ST_REQ;
                        flags_INTERRUPT <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // Ack takes precedence over a withdraw seen in the same cycle.
                    if (ctrl_INTERRUPT[0]) begin
                        in_service      <= sel_mask;
                        flags_INTERRUPT <= 1'b0;
                        state           <= ST_SVC;
                    end else if (!sel_pend || !sel_ie) begin
                        flags_INTERRUPT <= 1'b0;
                        state           <= ST_IDLE;
                    end
                end
                ST_SVC: begin
                    if (ctrl_INTERRUPT[1]) begin
                        in_service <= '0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state           <= ST_IDLE;
                    flags_INTERRUPT <= 1'b0;
                    in_service      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zueirai_int_ctrl.sv
// Directed bench for zueirai_int_ctrl: vector table plus hand-written reset/level sequences.
module tb_zueirai_int_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  irq_src;
    logic [11:0] ctrl_MEM;
    logic [7:0]  wdata_MEM;
    logic [7:0]  rdata_MEM;
    logic        hit_MEM;
    logic        flags_INTERRUPT;
    logic [1:0]  ctrl_INTERRUPT;
    logic [3:0]  in_service;

    int checks = 0;
    int errors = 0;

    zueirai_int_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .irq_src         (irq_src),
        .ctrl_MEM        (ctrl_MEM),
        .wdata_MEM       (wdata_MEM),
        .rdata_MEM       (rdata_MEM),
        .hit_MEM         (hit_MEM),
        .flags_INTERRUPT (flags_INTERRUPT),
        .ctrl_INTERRUPT  (ctrl_INTERRUPT),
        .in_service      (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  irq;
        logic [1:0]  ci;
        logic [11:0] mem;
        logic [7:0]  wd;
        logic [7:0]  erd;
        logic        ehit;
        logic        efl;
        logic [3:0]  eisv;
    } vec_t;

    vec_t vt[$];

    localparam logic [11:0] NOP = 12'h000;

    function automatic logic [11:0] mw(input logic [7:0] a);
        return {1'b1, 1'b0, 2'd3, a};
    endfunction

    function automatic logic [11:0] mr(input logic [1:0] pg, input logic [7:0] a);
        return {1'b0, 1'b1, pg, a};
    endfunction

    task automatic add(input logic [3:0] irq, input logic [1:0] ci, input logic [11:0] mem,
                       input logic [7:0] wd, input logic [7:0] erd, input logic ehit,
                       input logic efl, input logic [3:0] eisv);
        vec_t v;
        v.irq = irq; v.ci = ci; v.mem = mem; v.wd = wd;
        v.erd = erd; v.ehit = ehit; v.efl = efl; v.eisv = eisv;
        vt.push_back(v);
    endtask

    task automatic chk(input string nm, input int row, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %02h expected %02h", nm, row, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] irq, input logic [1:0] ci, input logic [11:0] mem,
                         input logic [7:0] wd);
        irq_src        = irq;
        ctrl_INTERRUPT = ci;
        ctrl_MEM       = mem;
        wdata_MEM      = wd;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        drive(4'h0, 2'b00, mr(2'd0, 8'hFE), 8'h00);

        // irq  ci  mem             wd     rdata hit fl isv
        add(4'h0, 2'd0, mw(8'hF0),       8'h01, 8'h00, 0, 0, 4'h0);
        add(4'h0, 2'd0, mw(8'hF3),       8'h40, 8'h00, 0, 0, 4'h0);
        add(4'h0, 2'd0, mw(8'hF4),       8'h02, 8'h00, 0, 0, 4'h0);
        add(4'h0, 2'd0, mr(2'd3, 8'hF0), 8'h00, 8'h01, 1, 0, 4'h0);
        add(4'h1, 2'd0, NOP,             8'h00, 8'h00, 0, 0, 4'h0);
        add(4'h0, 2'd0, mr(2'd3, 8'hF1), 8'h00, 8'h01, 1, 0, 4'h0);
        add(4'h0, 2'd0, mr(2'd0, 8'hFE), 8'h00, 8'h40, 1, 1, 4'h0);
        add(4'h0, 2'd0, mr(2'd0, 8'hFF), 8'h00, 8'h02, 1, 1, 4'h0);
        add(4'h0, 2'd0, mr(2'd3, 8'hF2), 8'h00, 8'h40, 1, 1, 4'h0);
        add(4'h0, 2'd1, NOP,             8'h00, 8'h00, 0, 1, 4'h0);
        add(4'h0, 2'd0, mr(2'd3, 8'hF1), 8'h00, 8'h00, 1, 0, 4'h1);
        add(4'h0, 2'd0, mr(2'd3, 8'hF2), 8'h00, 8'h80, 1, 0, 4'h1);
        add(4'h0, 2'd2, NOP,             8'h00, 8'h00, 0, 0, 4'h1);
        add(4'h0, 2'd1, mr(2'd3, 8'hF2), 8'h00, 8'h00, 1, 0, 4'h0);
        // two sources rise together: lower index wins, the other follows after RETI
        add(4'h0, 2'd0, mw(8'hF0),       8'h0F, 8'h00, 0, 0, 4'h0);
        add(4'h6, 2'd0, NOP,             8'h00, 8'h00, 0, 0, 4'h0);
        add(4'h0, 2'd0, mr(2'd3, 8'hF2), 8'h00, 8'h00, 1, 0, 4'h0);
        add(4'h0, 2'd0, mr(2'd3, 8'hF2), 8'h00, 8'h41, 1, 1, 4'h0);
        add(4'h0, 2'd1, NOP,             8'h00, 8'h00, 0, 1, 4'h0);
        add(4'h0, 2'd0, mr(2'd3, 8'hF1), 8'h00, 8'h04, 1, 0, 4'h2);
        add(4'h0, 2'd2, NOP,             8'h00, 8'h00, 0, 0, 4'h2);
        add(4'h0, 2'd0, mr(2'd3, 8'hF2), 8'h00, 8'h01, 1, 0, 4'h0);
        add(4'h0, 2'd0, mr(2'd3, 8'hF2), 8'h00, 8'h42, 1, 1, 4'h0);
        add(4'h0, 2'd1, NOP,             8'h00, 8'h00, 0, 1, 4'h0);
        add(4'h0, 2'd2, NOP,             8'h00, 8'h00, 0, 0, 4'h4);
        add(4'h0, 2'd3, mr(2'd1, 8'hF0), 8'h00, 8'h00, 0, 0, 4'h0);
        // W1C of the requested source while in REQ withdraws the request
        add(4'h8, 2'd0, NOP,             8'h00, 8'h00, 0, 0, 4'h0);
        add(4'h0, 2'd0, NOP,             8'h00, 8'h00, 0, 0, 4'h0);
        add(4'h0, 2'd0, mr(2'd3, 8'hF2), 8'h00, 8'h43, 1, 1, 4'h0);
        add(4'h0, 2'd0, mw(8'hF1),       8'h08, 8'h00, 0, 1, 4'h0);
        add(4'h0, 2'd0, mr(2'd3, 8'hF2), 8'h00, 8'h43, 1, 1, 4'h0);
        add(4'h0, 2'd0, mr(2'd3, 8'hF2), 8'h00, 8'h03, 1, 0, 4'h0);
        add(4'h0, 2'd0, mr(2'd3, 8'hF1), 8'h00, 8'h00, 1, 0, 4'h0);
        // edge and W1C of the same bit in one cycle: the edge wins
        add(4'h1, 2'd0, mw(8'hF1),       8'h01, 8'h00, 0, 0, 4'h0);
        add(4'h1, 2'd0, mr(2'd3, 8'hF1), 8'h00, 8'h01, 1, 0, 4'h0);
        add(4'h1, 2'd0, mr(2'd3, 8'hF2), 8'h00, 8'h40, 1, 1, 4'h0);
        add(4'h1, 2'd1, NOP,             8'h00, 8'h00, 0, 1, 4'h0);
        add(4'h1, 2'd0, mr(2'd3, 8'hF1), 8'h00, 8'h00, 1, 0, 4'h1);
        // re-arrival during service: pending, ack ignored in SVC, served after RETI
        add(4'h0, 2'd0, NOP,             8'h00, 8'h00, 0, 0, 4'h1);
        add(4'h1, 2'd0, NOP,             8'h00, 8'h00, 0, 0, 4'h1);
        add(4'h0, 2'd1, mr(2'd3, 8'hF1), 8'h00, 8'h01, 1, 0, 4'h1);
        add(4'h0, 2'd0, mr(2'd3, 8'hF2), 8'h00, 8'h80, 1, 0, 4'h1);
        add(4'h0, 2'd2, NOP,             8'h00, 8'h00, 0, 0, 4'h1);
        add(4'h0, 2'd0, NOP,             8'h00, 8'h00, 0, 0, 4'h0);
        add(4'h0, 2'd0, mr(2'd3, 8'hF2), 8'h00, 8'h40, 1, 1, 4'h0);
        add(4'h0, 2'd1, NOP,             8'h00, 8'h00, 0, 1, 4'h0);
        add(4'h0, 2'd0, mr(2'd3, 8'hF2), 8'h00, 8'h80, 1, 0, 4'h1);

        // reset state
        @(negedge clk); #1;
        chk("rst_hit", -1, 8'(hit_MEM), 8'h00);
        chk("rst_rdata", -1, rdata_MEM, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        drive(4'h0, 2'b00, mr(2'd3, 8'hF2), 8'h00);
        #1;
        chk("rst_flags", -1, 8'(flags_INTERRUPT), 8'h00);
        chk("rst_isv", -1, 8'(in_service), 8'h00);
        chk("rst_status", -1, rdata_MEM, 8'h00);

        for (int k = 0; k < vt.size(); k++) begin
            @(negedge clk);
            drive(vt[k].irq, vt[k].ci, vt[k].mem, vt[k].wd);
            #1;
            chk("rdata", k, rdata_MEM, vt[k].erd);
            chk("hit", k, 8'(hit_MEM), 8'(vt[k].ehit));
            chk("flags", k, 8'(flags_INTERRUPT), 8'(vt[k].efl));
            chk("in_service", k, 8'(in_service), 8'(vt[k].eisv));
        end

        // reset while in SVC
        @(negedge clk);
        rst = 1'b1;
        drive(4'h0, 2'b00, mr(2'd0, 8'hFE), 8'h00);
        #1;
        chk("rst_svc_hit", 100, 8'(hit_MEM), 8'h00);
        chk("rst_svc_rdata", 100, rdata_MEM, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        drive(4'h0, 2'b00, mr(2'd3, 8'hF0), 8'h00);
        #1;
        chk("rst_svc_isv", 101, 8'(in_service), 8'h00);
        chk("rst_svc_flags", 101, 8'(flags_INTERRUPT), 8'h00);
        chk("rst_svc_ie", 101, rdata_MEM, 8'h00);
        ctrl_MEM = mr(2'd0, 8'hFE);
        #1;
        chk("rst_svc_vecpc", 102, rdata_MEM, 8'h00);
        ctrl_MEM = mr(2'd1, 8'hF0);
        #1;
        chk("page1_hit", 103, 8'(hit_MEM), 8'h00);
        chk("page1_rdata", 103, rdata_MEM, 8'h00);

        // level-high line with IE=0: one PEND set, cleared mid-hold, never re-set
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 4) drive(4'h1, 2'b00, mw(8'hF1), 8'h01);
            else        drive(4'h1, 2'b00, mr(2'd3, 8'hF1), 8'h00);
            #1;
            if (c == 2) chk("hold_pend_set", 110, rdata_MEM, 8'h01);
        end
        @(negedge clk);
        drive(4'h1, 2'b00, mr(2'd3, 8'hF1), 8'h00);
        #1;
        chk("hold_no_retrigger", 111, rdata_MEM, 8'h00);

        // enable, pulse, then ack and RETI asserted together count as ack only
        @(negedge clk);
        drive(4'h0, 2'b00, mw(8'hF0), 8'h01);
        @(negedge clk);
        drive(4'h1, 2'b00, NOP, 8'h00);
        @(negedge clk);
        drive(4'h0, 2'b00, NOP, 8'h00);
        #1;
        n = 0;
        while (!flags_INTERRUPT && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        chk("flag_wait", 120, 8'(flags_INTERRUPT), 8'h01);
        @(negedge clk);
        drive(4'h0, 2'b11, NOP, 8'h00);
        @(negedge clk);
        drive(4'h0, 2'b00, mr(2'd3, 8'hF2), 8'h00);
        #1;
        chk("both_bits_isv", 121, 8'(in_service), 8'h01);
        chk("both_bits_status", 121, rdata_MEM, 8'h80);
        chk("both_bits_flags", 121, 8'(flags_INTERRUPT), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
